// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: IDLE/RUN/DONE control, PC stepping,
// jump-table redirects and a saturating run-cycle counter.
module fetch_seq #(
  parameter logic [15:0] START_PC  = 16'h0000,
  parameter int          LUT_DEPTH = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        BranchTaken,
  input  logic [4:0]  LutIndex,
  input  logic        CfgWe,
  input  logic [4:0]  CfgAddr,
  input  logic [15:0] CfgData,
  output logic [15:0] PC,
  output logic        FetchValid,
  output logic        Done,
  output logic [15:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        fv_q;
  logic        done_q;
  logic [15:0] lut_q [LUT_DEPTH];
  logic [15:0] tgt;

  // Jump-table read is combinational, so a same-cycle write is not seen.
  assign tgt = lut_q[LutIndex];

  // Counter saturates rather than wrapping on very long runs.
  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Sequencer FSM with registered PC, counter and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cnt_q   <= 16'h0000;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q <= S_RUN;
            pc_q    <= START_PC;
            cnt_q   <= 16'h0000;
            fv_q    <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            cnt_q <= cnt_d;
            if (Halt) begin
              state_q <= S_DONE;
              fv_q    <= 1'b0;
              done_q  <= 1'b1;
            end else if (BranchTaken) begin
              pc_q <= tgt;
            end else begin
              pc_q <= pc_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          fv_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Jump-table storage: cleared on reset, written in any state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= 16'h0000;
      end
    end else if (CfgWe) begin
      lut_q[CfgAddr] <= CfgData;
    end
  end

  assign PC         = pc_q;
  assign FetchValid = fv_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: directed vector table followed by
// randomized traffic checked against a behavioural model.
module tb_fetch_seq;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, BranchTaken;
  logic [4:0]  LutIndex, CfgAddr;
  logic        CfgWe;
  logic [15:0] CfgData;
  logic [15:0] PC, CycleCount;
  logic        FetchValid, Done;

  int n_vec = 0;
  int n_err = 0;

  fetch_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .Halt(Halt), .BranchTaken(BranchTaken), .LutIndex(LutIndex),
    .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .PC(PC), .FetchValid(FetchValid), .Done(Done),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, start, stall, halt, br;
    logic [4:0]  idx;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [15:0] pc;
    logic        fv, dn;
    logic [15:0] cnt;
  } vec_t;

  // Behavioural model: state 0=idle 1=run 2=done.
  int m_st, m_pc, m_cnt;
  int m_lut [32];

  function automatic vec_t mk(
    input logic rst, start, stall, halt, br,
    input logic [4:0] idx, input logic we,
    input logic [4:0] wa, input logic [15:0] wd,
    input logic [15:0] pc, input logic fv, dn,
    input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.stall = stall;
    v.halt = halt; v.br = br; v.idx = idx;
    v.we = we; v.wa = wa; v.wd = wd;
    v.pc = pc; v.fv = fv; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic model_step(input vec_t v);
    int tgt;
    if (v.rst) begin
      m_st = 0; m_pc = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) m_lut[i] = 0;
    end else begin
      tgt = m_lut[v.idx];
      if (m_st != 1) begin
        if (v.start) begin
          m_st = 1; m_pc = 0; m_cnt = 0;
        end
      end else if (!v.stall) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (v.halt) m_st = 2;
        else if (v.br) m_pc = tgt;
        else m_pc = (m_pc + 1) % 65536;
      end
      if (v.we) m_lut[v.wa] = v.wd;
    end
  endtask

  task automatic apply(input vec_t v);
    Reset = v.rst; Start = v.start; Stall = v.stall;
    Halt = v.halt; BranchTaken = v.br; LutIndex = v.idx;
    CfgWe = v.we; CfgAddr = v.wa; CfgData = v.wd;
    model_step(v);
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int step,
                     input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h",
               nm, step, act, exp);
    end
  endtask

  vec_t tbl [27];

  initial begin
    vec_t v;
    // rst st sl hl br idx we wa wd | pc fv dn cnt
    tbl[0]  = mk(1,0,0,0,0,0,0,0,0,       16'h0000,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,1,2,16'h0452,16'h0000,0,0,0);
    tbl[2]  = mk(0,1,0,0,0,0,0,0,0,       16'h0000,1,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,0,0,0,       16'h0001,1,0,1);
    tbl[4]  = mk(0,1,0,0,0,0,0,0,0,       16'h0002,1,0,2);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0,       16'h0003,1,0,3);
    tbl[6]  = mk(0,0,0,0,0,0,0,0,0,       16'h0004,1,0,4);
    tbl[7]  = mk(0,0,0,0,0,0,0,0,0,       16'h0005,1,0,5);
    tbl[8]  = mk(0,0,0,0,1,2,0,0,0,       16'h0452,1,0,6);
    tbl[9]  = mk(0,0,0,0,0,0,1,3,16'h0007,16'h0453,1,0,7);
    tbl[10] = mk(0,0,0,0,1,3,0,0,0,       16'h0007,1,0,8);
    tbl[11] = mk(0,0,1,0,1,2,0,0,0,       16'h0007,1,0,8);
    tbl[12] = mk(0,0,1,1,1,2,0,0,0,       16'h0007,1,0,8);
    tbl[13] = mk(0,0,1,0,1,2,0,0,0,       16'h0007,1,0,8);
    tbl[14] = mk(0,0,0,0,0,0,1,4,16'h04A1,16'h0008,1,0,9);
    tbl[15] = mk(0,0,0,0,1,4,0,0,0,       16'h04A1,1,0,10);
    tbl[16] = mk(0,0,0,1,1,2,0,0,0,       16'h04A1,0,1,11);
    tbl[17] = mk(0,0,0,0,1,2,0,0,0,       16'h04A1,0,1,11);
    tbl[18] = mk(0,1,0,0,0,0,1,9,16'h0100,16'h0000,1,0,0);
    tbl[19] = mk(0,0,0,0,1,9,1,9,16'h0200,16'h0100,1,0,1);
    tbl[20] = mk(0,0,0,0,1,9,1,5,16'hFFFF,16'h0200,1,0,2);
    tbl[21] = mk(0,0,0,0,1,5,0,0,0,       16'hFFFF,1,0,3);
    tbl[22] = mk(0,0,0,0,0,0,0,0,0,       16'h0000,1,0,4);
    tbl[23] = mk(1,1,0,0,0,0,0,0,0,       16'h0000,0,0,0);
    tbl[24] = mk(0,0,0,0,0,0,0,0,0,       16'h0000,0,0,0);
    tbl[25] = mk(0,1,0,0,0,0,0,0,0,       16'h0000,1,0,0);
    tbl[26] = mk(0,0,0,0,1,2,0,0,0,       16'h0000,1,0,1);

    for (int i = 0; i < 27; i++) begin
      apply(tbl[i]);
      chk("pc",   i, PC,         tbl[i].pc);
      chk("fv",   i, {15'd0, FetchValid}, {15'd0, tbl[i].fv});
      chk("done", i, {15'd0, Done},       {15'd0, tbl[i].dn});
      chk("cnt",  i, CycleCount, tbl[i].cnt);
    end

    v = mk(1,0,0,0,0,0,0,0,0,0,0,0,0);
    apply(v);
    for (int i = 0; i < 3000; i++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.start = ($urandom_range(0, 7) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.halt  = ($urandom_range(0, 39) == 0);
      v.br    = ($urandom_range(0, 3) == 0);
      v.idx   = 5'($urandom_range(0, 31));
      v.we    = ($urandom_range(0, 3) == 0);
      v.wa    = 5'($urandom_range(0, 31));
      v.wd    = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                            : 16'($urandom);
      apply(v);
      chk("r_pc",   i, PC,         16'(m_pc));
      chk("r_fv",   i, {15'd0, FetchValid}, {15'd0, m_st == 1});
      chk("r_done", i, {15'd0, Done},       {15'd0, m_st == 2});
      chk("r_cnt",  i, CycleCount, 16'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
